// File: rtl/load_store_unit.sv
// Load/store sequencer: effective-address calc, one-cycle memory access, then base/load writebacks.
// Optional macro ALIGN_CHECK_EN routes misaligned accesses to a one-cycle FAULT state.
module load_store_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_load,
  input  logic [DATA_W-1:0]   req_base,
  input  logic [OFFSET_W-1:0] req_offset,
  input  logic                req_up,
  input  logic                req_pre,
  input  logic                req_wback,
  input  logic [3:0]          req_rn,
  input  logic [3:0]          req_rd,
  input  logic [DATA_W-1:0]   req_store_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_ldr_str_en,
  output logic                mem_load_en,
  output logic                mem_store_en,
  input  logic [DATA_W-1:0]   mem_read_data,
  output logic                wb_valid,
  output logic [3:0]          wb_reg,
  output logic [DATA_W-1:0]   wb_data,
  output logic                fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WB_BASE,
    ST_WB_LOAD
`ifdef ALIGN_CHECK_EN
    , ST_FAULT
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                is_load_q, is_load_d;
  logic                base_upd_q, base_upd_d;
  logic [3:0]          rn_q, rn_d;
  logic [3:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   ea_q, ea_d;
  logic [DATA_W-1:0]   load_buf_q, load_buf_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                mem_ldr_str_en_q, mem_ldr_str_en_d;
  logic                mem_load_en_q, mem_load_en_d;
  logic                mem_store_en_q, mem_store_en_d;
  logic                wb_valid_q, wb_valid_d;
  logic [3:0]          wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
`ifdef ALIGN_CHECK_EN
  logic                fault_q, fault_d;
`endif

  logic [DATA_W-1:0]   off_ext;
  logic [DATA_W-1:0]   ea_in;
  logic [DATA_W-1:0]   acc_in;
  logic                unused_addr_bits;

  // Address arithmetic wraps modulo 2^DATA_W; only the word-index bits reach memory.
  assign off_ext = DATA_W'(req_offset);
  assign ea_in   = req_up ? (req_base + off_ext) : (req_base - off_ext);
  assign acc_in  = req_pre ? ea_in : req_base;
  assign unused_addr_bits = ^{acc_in[DATA_W-1:ADDR_W+2], acc_in[1:0]};

  always_comb begin
    state_d          = state_q;
    ready_d          = 1'b0;
    is_load_d        = is_load_q;
    base_upd_d       = base_upd_q;
    rn_d             = rn_q;
    rd_d             = rd_q;
    ea_d             = ea_q;
    load_buf_d       = load_buf_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_ldr_str_en_d = 1'b0;
    mem_load_en_d    = 1'b0;
    mem_store_en_d   = 1'b0;
    wb_valid_d       = 1'b0;
    wb_reg_d         = wb_reg_q;
    wb_data_d        = wb_data_q;
`ifdef ALIGN_CHECK_EN
    fault_d          = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d          = 1'b0;
          is_load_d        = req_is_load;
          base_upd_d       = !req_pre || req_wback;
          rn_d             = req_rn;
          rd_d             = req_rd;
          ea_d             = ea_in;
          mem_addr_d       = acc_in[ADDR_W+1:2];
          mem_write_data_d = req_store_data;
`ifdef ALIGN_CHECK_EN
          if (acc_in[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else
`endif
          begin
            state_d          = ST_ACCESS;
            mem_ldr_str_en_d = 1'b1;
            mem_load_en_d    = req_is_load;
            mem_store_en_d   = !req_is_load;
          end
        end
      end

      ST_ACCESS: begin
        load_buf_d = mem_read_data;
        if (base_upd_q) begin
          state_d    = ST_WB_BASE;
          wb_valid_d = 1'b1;
          wb_reg_d   = rn_q;
          wb_data_d  = ea_q;
        end else if (is_load_q) begin
          // No base update: load data is already on the bus, write it back next cycle.
          state_d    = ST_WB_LOAD;
          wb_valid_d = 1'b1;
          wb_reg_d   = rd_q;
          wb_data_d  = mem_read_data;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end

      ST_WB_BASE: begin
        if (is_load_q) begin
          state_d    = ST_WB_LOAD;
          wb_valid_d = 1'b1;
          wb_reg_d   = rd_q;
          wb_data_d  = load_buf_q;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end

      ST_WB_LOAD: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

`ifdef ALIGN_CHECK_EN
      ST_FAULT: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      ready_q          <= 1'b0;
      is_load_q        <= 1'b0;
      base_upd_q       <= 1'b0;
      rn_q             <= '0;
      rd_q             <= '0;
      ea_q             <= '0;
      load_buf_q       <= '0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      mem_ldr_str_en_q <= 1'b0;
      mem_load_en_q    <= 1'b0;
      mem_store_en_q   <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_reg_q         <= '0;
      wb_data_q        <= '0;
`ifdef ALIGN_CHECK_EN
      fault_q          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      ready_q          <= ready_d;
      is_load_q        <= is_load_d;
      base_upd_q       <= base_upd_d;
      rn_q             <= rn_d;
      rd_q             <= rd_d;
      ea_q             <= ea_d;
      load_buf_q       <= load_buf_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_ldr_str_en_q <= mem_ldr_str_en_d;
      mem_load_en_q    <= mem_load_en_d;
      mem_store_en_q   <= mem_store_en_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_q         <= wb_reg_d;
      wb_data_q        <= wb_data_d;
`ifdef ALIGN_CHECK_EN
      fault_q          <= fault_d;
`endif
    end
  end

  assign req_ready      = ready_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_ldr_str_en = mem_ldr_str_en_q;
  assign mem_load_en    = mem_load_en_q;
  assign mem_store_en   = mem_store_en_q;
  assign wb_valid       = wb_valid_q;
  assign wb_reg         = wb_reg_q;
  assign wb_data        = wb_data_q;
`ifdef ALIGN_CHECK_EN
  assign fault          = fault_q;
`else
  assign fault          = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word memory model (combinational read, clocked write).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic [31:0] req_base;
  logic [11:0] req_offset;
  logic        req_up;
  logic        req_pre;
  logic        req_wback;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [31:0] req_store_data;
  logic [3:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_ldr_str_en;
  logic        mem_load_en;
  logic        mem_store_en;
  logic [31:0] mem_read_data;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        fault;

  logic        mem_init;
  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_base(req_base), .req_offset(req_offset), .req_up(req_up), .req_pre(req_pre),
    .req_wback(req_wback), .req_rn(req_rn), .req_rd(req_rd), .req_store_data(req_store_data),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ldr_str_en(mem_ldr_str_en),
    .mem_load_en(mem_load_en), .mem_store_en(mem_store_en), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .fault(fault)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_store_en) begin
      mem[mem_addr] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [31:0] base, input logic [11:0] off,
                       input logic up, input logic pre, input logic wb,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [31:0] sd);
    req_valid      = 1'b1;
    req_is_load    = ld;
    req_base       = base;
    req_offset     = off;
    req_up         = up;
    req_pre        = pre;
    req_wback      = wb;
    req_rn         = rn;
    req_rd         = rd;
    req_store_data = sd;
  endtask

  initial begin
    rst = 1'b0; mem_init = 1'b1; req_valid = 1'b0;
    drive(1'b0, 32'h0, 12'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    req_valid = 1'b0;
    #3;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_en", 32'(mem_ldr_str_en), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    tick(); tick();
    rst = 1'b1; mem_init = 1'b0;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // 1: STR pre, no writeback
    drive(1'b0, 32'h10, 12'd4, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 32'hDEAD_BEEF);
    tick(); req_valid = 1'b0;
    check("t1_addr", 32'(mem_addr), 32'd5);
    check("t1_store_en", 32'(mem_store_en), 32'd1);
    check("t1_ldr_str_en", 32'(mem_ldr_str_en), 32'd1);
    check("t1_load_en", 32'(mem_load_en), 32'd0);
    check("t1_wdata", mem_write_data, 32'hDEAD_BEEF);
    check("t1_ready_busy", 32'(req_ready), 32'd0);
    tick();
    check("t1_no_wb", 32'(wb_valid), 32'd0);
    check("t1_ready_c2", 32'(req_ready), 32'd1);
    check("t1_strobe_off", 32'(mem_store_en), 32'd0);
    check("t1_mem5", mem[5], 32'hDEAD_BEEF);
    $display("TXN 1: STR base=0x10 +4 pre -> mem[5]");

    // 2: LDR same address
    drive(1'b1, 32'h10, 12'd4, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 32'h0);
    tick(); req_valid = 1'b0;
    check("t2_load_en", 32'(mem_load_en), 32'd1);
    check("t2_store_en", 32'(mem_store_en), 32'd0);
    check("t2_addr", 32'(mem_addr), 32'd5);
    tick();
    check("t2_wb_valid", 32'(wb_valid), 32'd1);
    check("t2_wb_reg", 32'(wb_reg), 32'd3);
    check("t2_wb_data", wb_data, 32'hDEAD_BEEF);
    tick();
    check("t2_wb_done", 32'(wb_valid), 32'd0);
    check("t2_ready", 32'(req_ready), 32'd1);
    $display("TXN 2: LDR r3 <- mem[5]");

    // 3: LDR post-indexed
    drive(1'b1, 32'h08, 12'd8, 1'b1, 1'b0, 1'b0, 4'd2, 4'd4, 32'h0);
    tick(); req_valid = 1'b0;
    check("t3_addr", 32'(mem_addr), 32'd2);
    check("t3_load_en", 32'(mem_load_en), 32'd1);
    tick();
    check("t3_wb1_valid", 32'(wb_valid), 32'd1);
    check("t3_wb1_reg", 32'(wb_reg), 32'd2);
    check("t3_wb1_data", wb_data, 32'h10);
    tick();
    check("t3_wb2_valid", 32'(wb_valid), 32'd1);
    check("t3_wb2_reg", 32'(wb_reg), 32'd4);
    check("t3_wb2_data", wb_data, 32'hA000_0002);
    tick();
    check("t3_ready", 32'(req_ready), 32'd1);
    check("t3_wb_done", 32'(wb_valid), 32'd0);
    $display("TXN 3: LDR post r2=0x10, r4 <- mem[2]");

    // 4: LDR pre+wback down, rn==rd, next request held valid
    drive(1'b1, 32'h04, 12'd4, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 32'h0);
    tick();
    drive(1'b0, 32'h20, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 32'h1234_5678);
    check("t4_addr", 32'(mem_addr), 32'd0);
    check("t4_load_en", 32'(mem_load_en), 32'd1);
    tick();
    check("t4_wb1_reg", 32'(wb_reg), 32'd1);
    check("t4_wb1_data", wb_data, 32'h0);
    check("t4_busy_c2", 32'(req_ready), 32'd0);
    tick();
    check("t4_wb2_valid", 32'(wb_valid), 32'd1);
    check("t4_wb2_reg", 32'(wb_reg), 32'd1);
    check("t4_wb2_data", wb_data, 32'hA000_0000);
    check("t4_busy_c3", 32'(req_ready), 32'd0);
    tick();
    check("t4_ready_idle", 32'(req_ready), 32'd1);
    check("t4_no_access", 32'(mem_ldr_str_en), 32'd0);
    tick(); req_valid = 1'b0;
    check("t4_next_store", 32'(mem_store_en), 32'd1);
    check("t4_next_addr", 32'(mem_addr), 32'd8);
    tick();
    check("t4_mem8", mem[8], 32'h1234_5678);
    $display("TXN 4: LDR pre!/down r1 then queued STR mem[8]");

    // Boundary: address wrap below zero, STR with writeback issues only the base update
    drive(1'b0, 32'h0, 12'd4, 1'b0, 1'b1, 1'b1, 4'd5, 4'd6, 32'h0BAD_F00D);
    tick(); req_valid = 1'b0;
    check("wrap_addr", 32'(mem_addr), 32'd15);
    check("wrap_store_en", 32'(mem_store_en), 32'd1);
    tick();
    check("wrap_wb_reg", 32'(wb_reg), 32'd5);
    check("wrap_wb_data", wb_data, 32'hFFFF_FFFC);
    tick();
    check("wrap_no_ld_wb", 32'(wb_valid), 32'd0);
    check("wrap_ready", 32'(req_ready), 32'd1);
    check("wrap_mem15", mem[15], 32'h0BAD_F00D);
    $display("TXN W: STR pre!/down from 0 -> mem[15], r5=0xFFFFFFFC");

    // 5: reset during ACCESS of an LDR
    drive(1'b1, 32'h04, 12'd0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd8, 32'h0);
    tick(); req_valid = 1'b0;
    check("t5_in_access", 32'(mem_load_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_en", 32'(mem_ldr_str_en), 32'd0);
    check("t5_async_load", 32'(mem_load_en), 32'd0);
    check("t5_async_ready", 32'(req_ready), 32'd0);
    check("t5_async_wb_reg", 32'(wb_reg), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_wb", 32'(wb_valid), 32'd0);
      check("t5_no_strobe", 32'(mem_ldr_str_en), 32'd0);
    end
    check("t5_ready", 32'(req_ready), 32'd1);
    $display("TXN 5: reset during ACCESS aborts LDR");

    // 6: misaligned STR
    drive(1'b0, 32'h11, 12'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 32'h55AA_55AA);
    tick(); req_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
    check("t6_fault", 32'(fault), 32'd1);
    check("t6_no_store", 32'(mem_store_en), 32'd0);
    tick();
    check("t6_fault_off", 32'(fault), 32'd0);
    check("t6_no_store2", 32'(mem_store_en), 32'd0);
    check("t6_no_wb", 32'(wb_valid), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    check("t6_mem4", mem[4], 32'hA000_0004);
`else
    check("t6_fault", 32'(fault), 32'd0);
    check("t6_store", 32'(mem_store_en), 32'd1);
    check("t6_addr", 32'(mem_addr), 32'd4);
    tick();
    check("t6_mem4", mem[4], 32'h55AA_55AA);
    check("t6_ready", 32'(req_ready), 32'd1);
`endif
    $display("TXN 6: STR base=0x11 misaligned");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
